// File: rtl/branch_resolve_if.sv
// Request/result bundle between issue logic and the execute-stage branch resolver.
// The slave modport is the resolver's view; master is the driver/consumer side.
interface branch_resolve_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [XLEN-1:0]  in_imm;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic [XLEN-1:0]  out_target;
    logic [XLEN-1:0]  out_link;
    logic             out_misalign;
    logic             out_illegal;
    logic [CNT_W-1:0] taken_count;

    modport slave (
        input  flush, in_valid, in_op, in_funct3, in_pc, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_taken, out_target, out_link, out_misalign, out_illegal,
               taken_count
    );

    modport master (
        output flush, in_valid, in_op, in_funct3, in_pc, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_link, out_misalign, out_illegal,
               taken_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver: compares operands, decides taken, forms target and link,
// and hands the result off through a single registered valid/ready entry.
module comparator_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic        eq,
    output logic        lt,
    output logic        gt
);
    // Magnitude compare in the requested signedness
    always_comb begin
        eq = (a == b);
        if (is_signed) begin
            lt = ($signed(a) < $signed(b));
        end else begin
            lt = (a < b);
        end
        gt = !eq && !lt;
    end
endmodule

module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input logic              clk,
    input logic              rst,
    branch_resolve_if.slave  bus
);
    logic            eq_s, lt_s, gt_s, is_signed_s;
    logic            in_ready_s, accept_s, transfer_s;
    logic            taken_s, illegal_s, misalign_s;
    logic [XLEN-1:0] target_s, link_s;

    logic             out_valid_r, out_taken_r, out_misalign_r, out_illegal_r;
    logic [XLEN-1:0]  out_target_r, out_link_r;
    logic [CNT_W-1:0] taken_count_r;

    assign is_signed_s = (bus.in_funct3 == 3'b100) || (bus.in_funct3 == 3'b101);

    comparator_32bit u_cmp (
        .a         (bus.in_rs1),
        .b         (bus.in_rs2),
        .is_signed (is_signed_s),
        .eq        (eq_s),
        .lt        (lt_s),
        .gt        (gt_s)
    );

    assign in_ready_s = !out_valid_r || bus.out_ready;
    assign accept_s   = bus.in_valid && in_ready_s && !bus.flush;
    assign transfer_s = out_valid_r && bus.out_ready;

    // Taken decision and redirect target for the incoming request
    always_comb begin
        taken_s   = 1'b0;
        illegal_s = 1'b0;
        target_s  = bus.in_pc + XLEN'(4);
        case (bus.in_op)
            2'b00: begin
                taken_s  = 1'b0;
                target_s = bus.in_pc + XLEN'(4);
            end
            2'b01: begin
                target_s = bus.in_pc + bus.in_imm;
                case (bus.in_funct3)
                    3'b000:  taken_s = eq_s;
                    3'b001:  taken_s = !eq_s;
                    3'b100:  taken_s = lt_s;
                    3'b110:  taken_s = lt_s;
                    3'b101:  taken_s = gt_s || eq_s;
                    3'b111:  taken_s = gt_s || eq_s;
                    default: begin
                        taken_s   = 1'b0;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            2'b10: begin
                taken_s  = 1'b1;
                target_s = bus.in_pc + bus.in_imm;
            end
            2'b11: begin
                taken_s  = 1'b1;
                target_s = (bus.in_rs1 + bus.in_imm) & ~XLEN'(1);
            end
            default: begin
                taken_s  = 1'b0;
                target_s = bus.in_pc + XLEN'(4);
            end
        endcase
        misalign_s = taken_s && (target_s[1] || target_s[0]);
        link_s     = bus.in_pc + XLEN'(4);
    end

    // Result entry and taken counter; a flushed entry is never counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r    <= 1'b0;
            out_taken_r    <= 1'b0;
            out_target_r   <= '0;
            out_link_r     <= '0;
            out_misalign_r <= 1'b0;
            out_illegal_r  <= 1'b0;
            taken_count_r  <= '0;
        end else begin
            if (transfer_s && out_taken_r && !bus.flush) begin
                taken_count_r <= taken_count_r + CNT_W'(1);
            end
            if (bus.flush) begin
                out_valid_r <= 1'b0;
            end else if (accept_s) begin
                out_valid_r    <= 1'b1;
                out_taken_r    <= taken_s;
                out_target_r   <= target_s;
                out_link_r     <= link_s;
                out_misalign_r <= misalign_s;
                out_illegal_r  <= illegal_s;
            end else if (transfer_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_taken    = out_taken_r;
    assign bus.out_target   = out_target_r;
    assign bus.out_link     = out_link_r;
    assign bus.out_misalign = out_misalign_r;
    assign bus.out_illegal  = out_illegal_r;
    assign bus.taken_count  = taken_count_r;
endmodule
